vga_tile_framebuffer: RTL and testbench
=======================================

VGA_TILE_FRAMEBUFFER -- requirements
Module: vga_tile_framebuffer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32, meaning cell edge in pixels (power of two, 8..64).
REQ-002 SHALL have parameter VIDEO_WIDTH, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter VIDEO_HEIGHT, default 480, meaning active lines per frame.
REQ-004 SHALL have parameter COLOR_BITS, default 3, meaning cell colour-index width; index 0 = empty.
REQ-005 SHALL have parameter BORDER_EN, default 1, meaning draw 1-pixel outline on occupied cells.
REQ-006 SHALL have derived localparams GRID_WIDTH=VIDEO_WIDTH/BLOCK_SIZE, GRID_HEIGHT=VIDEO_HEIGHT/BLOCK_SIZE, XW=$clog2(GRID_WIDTH), YW=$clog2(GRID_HEIGHT).
REQ-007 SHALL have ports: CLK  in  1  pixel clock; RESET_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: col  in  10  pixel column; row  in  9  pixel line; video_on  in  1  active-video qualifier.
REQ-009 SHALL have ports: wr_en  in  1  cell write strobe; wr_x  in  XW  cell column; wr_y  in  YW  cell row; wr_color  in  COLOR_BITS  cell value.
REQ-010 SHALL have ports: clear_req  in  1  whole-grid clear; collapse_req  in  1  line-collapse request; collapse_row  in  YW  row to remove.
REQ-011 SHALL have ports: busy  out  1  sweep in progress; done  out  1  one-cycle sweep-complete pulse.
REQ-012 SHALL have ports: red, green, blue  out  4 each  pixel colour.

Function
REQ-013 Grid storage SHALL be GRID_WIDTH*GRID_HEIGHT cells of COLOR_BITS, one display read port, one internal read port, one write port.
REQ-014 Display path SHALL be 2-cycle latency: stage 1 registers cell x/y (col/BLOCK_SIZE, row/BLOCK_SIZE), in-cell offsets, in-grid and video_on flags; stage 2 reads cell, applies palette, registers RGB.
REQ-015 RGB SHALL be 0 when delayed video_on=0 or pixel outside GRID_WIDTH*BLOCK_SIZE x GRID_HEIGHT*BLOCK_SIZE.
REQ-016 Empty cell SHALL output 0; occupied cell SHALL output palette[index]; with BORDER_EN=1, occupied-cell pixels at x-offset 0 or y-offset 0 SHALL output 4'h8 on all channels.
REQ-017 Palette 1..7 SHALL be cyan(0,F,F), yellow(F,F,0), purple(8,0,F), green(0,F,0), red(F,0,0), blue(0,0,F), orange(F,8,0).
REQ-018 Display read of a cell written in the same cycle SHALL return the old value.
REQ-019 wr_en SHALL write in IDLE only; ignored when busy=1 or wr_x>=GRID_WIDTH or wr_y>=GRID_HEIGHT.
REQ-020 FSM states: IDLE, CLEAR, SHIFT, TOPFILL.
REQ-021 IDLE->CLEAR on clear_req; IDLE->SHIFT on collapse_req with collapse_row in 1..GRID_HEIGHT-1; IDLE->TOPFILL on collapse_req with collapse_row=0; collapse_row>=GRID_HEIGHT ignored.
REQ-022 clear_req and collapse_req together in IDLE SHALL select CLEAR; requests and wr_en together SHALL drop wr_en.
REQ-023 CLEAR SHALL zero one cell per cycle, raster order, GRID_WIDTH*GRID_HEIGHT cycles.
REQ-024 SHIFT SHALL copy cell(x,y-1) to cell(x,y) one per cycle, y from collapse_row down to 1, x 0..GRID_WIDTH-1, then enter TOPFILL.
REQ-025 TOPFILL SHALL zero row 0 over GRID_WIDTH cycles, then return to IDLE.
REQ-026 busy SHALL be 1 in every non-IDLE state, registered; done SHALL pulse 1 in the cycle busy falls.
REQ-027 Requests while busy=1 SHALL be ignored, not queued.
REQ-028 Display path SHALL keep running during sweeps, showing partially updated grid.

Reset
REQ-029 While RESET_n=0: red/green/blue=0, done=0, busy=1, pipeline flags 0, FSM=CLEAR with cell counter 0.
REQ-030 Clear sweep SHALL start first cycle RESET_n=1; reset mid-sweep SHALL abort and restart the clear.

Structure
REQ-031 Shared package SHALL hold palette constants, FSM state encoding and border colour.
REQ-032 Grid storage SHALL be sub-module vga_tile_ram (param width/depth, sync display read, async internal read, one write port).

Verification
REQ-033 Reset 2 cycles, release -> busy=1 for 300 cycles, done pulse at cycle 300, all pixels 0.
REQ-034 Write (3,2)=4, scan col=100,row=70 -> RGB (0,F,0) two cycles later; col=96,row=70 -> (8,8,8).
REQ-035 Cells (5,9)=2,(5,8)=5; collapse_row=9 -> busy 9*20+20=200 cycles, then (5,9)=5, (5,8) = old (5,7), row 0 empty.
REQ-036 clear_req+collapse_req same cycle -> 300-cycle clear; wr_en during busy -> no cell change.
REQ-037 wr_x=20 or collapse_row=15 -> no effect, busy stays 0; video_on=0 -> RGB 0.
REQ-038 BLOCK_SIZE=16 -> 40x30 grid, write (39,29)=1 -> col=632,row=472 cyan.

Source files
------------

// File: rtl/vga_tile_framebuffer_pkg.sv
// Shared definitions for the tile framebuffer: sweep FSM encoding, border colour
// and the fixed 7-entry colour palette.
package vga_tile_framebuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_TOPFILL = 2'd3
    } state_t;

    localparam logic [11:0] BORDER_RGB = 12'h888;

    localparam logic [11:0] PAL_CYAN   = 12'h0FF;
    localparam logic [11:0] PAL_YELLOW = 12'hFF0;
    localparam logic [11:0] PAL_PURPLE = 12'h80F;
    localparam logic [11:0] PAL_GREEN  = 12'h0F0;
    localparam logic [11:0] PAL_RED    = 12'hF00;
    localparam logic [11:0] PAL_BLUE   = 12'h00F;
    localparam logic [11:0] PAL_ORANGE = 12'hF80;

    // Index 0 (empty) and any index beyond the palette render black.
    function automatic logic [11:0] palette(input logic [7:0] idx);
        logic [11:0] rgb;
        case (idx)
            8'd1:    rgb = PAL_CYAN;
            8'd2:    rgb = PAL_YELLOW;
            8'd3:    rgb = PAL_PURPLE;
            8'd4:    rgb = PAL_GREEN;
            8'd5:    rgb = PAL_RED;
            8'd6:    rgb = PAL_BLUE;
            8'd7:    rgb = PAL_ORANGE;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_tile_framebuffer_ram.sv
// Cell storage: registered display read port, combinational internal read port
// for the sweep engine, single write port.
module vga_tile_ram #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 300,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    disp_addr,
    output logic [WIDTH-1:0] disp_data,
    input  logic [AW-1:0]    int_addr,
    output logic [WIDTH-1:0] int_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus display read; a same-cycle write is seen by the next read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        disp_data <= mem[disp_addr];
    end

    assign int_data = mem[int_addr];

endmodule

// File: rtl/vga_tile_framebuffer.sv
// Tile-grid framebuffer: 2-cycle pixel render path plus a sweep engine that
// clears the grid or collapses one row (shift rows above down, blank row 0).
module vga_tile_framebuffer
    import vga_tile_framebuffer_pkg::*;
#(
    parameter int BLOCK_SIZE   = 32,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int COLOR_BITS   = 3,
    parameter int BORDER_EN    = 1
) (
    input  logic                                          CLK,
    input  logic                                          RESET_n,
    input  logic [9:0]                                    col,
    input  logic [8:0]                                    row,
    input  logic                                          video_on,
    input  logic                                          wr_en,
    input  logic [$clog2(VIDEO_WIDTH/BLOCK_SIZE)-1:0]     wr_x,
    input  logic [$clog2(VIDEO_HEIGHT/BLOCK_SIZE)-1:0]    wr_y,
    input  logic [COLOR_BITS-1:0]                         wr_color,
    input  logic                                          clear_req,
    input  logic                                          collapse_req,
    input  logic [$clog2(VIDEO_HEIGHT/BLOCK_SIZE)-1:0]    collapse_row,
    output logic                                          busy,
    output logic                                          done,
    output logic [3:0]                                    red,
    output logic [3:0]                                    green,
    output logic [3:0]                                    blue
);

    localparam int GRID_WIDTH  = VIDEO_WIDTH / BLOCK_SIZE;
    localparam int GRID_HEIGHT = VIDEO_HEIGHT / BLOCK_SIZE;
    localparam int XW          = $clog2(GRID_WIDTH);
    localparam int YW          = $clog2(GRID_HEIGHT);
    localparam int DEPTH       = GRID_WIDTH * GRID_HEIGHT;
    localparam int AW          = $clog2(DEPTH);
    localparam int OW          = $clog2(BLOCK_SIZE);

    localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
    localparam logic [XW-1:0] LAST_X    = XW'(GRID_WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y    = YW'(GRID_HEIGHT - 1);

    function automatic logic [AW-1:0] cell_addr(input int x, input int y);
        return AW'(y * GRID_WIDTH + x);
    endfunction

    state_t                state_r;
    logic [AW-1:0]         cnt_r;
    logic [XW-1:0]         x_r;
    logic [YW-1:0]         y_r;

    logic [9:0]            cell_col_s;
    logic [8:0]            cell_row_s;
    logic                  in_grid_s;
    logic [AW-1:0]         disp_addr_s;
    logic [COLOR_BITS-1:0] cell_data_s;
    logic                  vid_r;
    logic                  in_grid_r;
    logic [OW-1:0]         xoff_r;
    logic [OW-1:0]         yoff_r;
    logic [11:0]           pix_s;

    logic                  ram_we_s;
    logic [AW-1:0]         ram_waddr_s;
    logic [COLOR_BITS-1:0] ram_wdata_s;
    logic [AW-1:0]         src_addr_s;
    logic [COLOR_BITS-1:0] src_data_s;

    assign cell_col_s  = col >> OW;
    assign cell_row_s  = row >> OW;
    assign in_grid_s   = (col < 10'(GRID_WIDTH * BLOCK_SIZE)) && (row < 9'(GRID_HEIGHT * BLOCK_SIZE));
    // Off-grid pixels read cell 0 so the RAM is never addressed out of range.
    assign disp_addr_s = in_grid_s ? cell_addr(32'(cell_col_s), 32'(cell_row_s)) : {AW{1'b0}};

    vga_tile_ram #(
        .WIDTH (COLOR_BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (CLK),
        .disp_addr (disp_addr_s),
        .disp_data (cell_data_s),
        .int_addr  (src_addr_s),
        .int_data  (src_data_s),
        .wr_en     (ram_we_s & RESET_n),
        .wr_addr   (ram_waddr_s),
        .wr_data   (ram_wdata_s)
    );

    // Stage 1: qualifiers and in-cell offsets travel alongside the cell read.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            vid_r     <= 1'b0;
            in_grid_r <= 1'b0;
            xoff_r    <= {OW{1'b0}};
            yoff_r    <= {OW{1'b0}};
        end else begin
            vid_r     <= video_on;
            in_grid_r <= in_grid_s;
            xoff_r    <= col[OW-1:0];
            yoff_r    <= row[OW-1:0];
        end
    end

    // Colour selection for the cell under the beam.
    always_comb begin
        pix_s = 12'h000;
        if (vid_r && in_grid_r && (cell_data_s != {COLOR_BITS{1'b0}})) begin
            if ((BORDER_EN != 0) && ((xoff_r == {OW{1'b0}}) || (yoff_r == {OW{1'b0}}))) begin
                pix_s = BORDER_RGB;
            end else begin
                pix_s = palette(8'(cell_data_s));
            end
        end else begin
            pix_s = 12'h000;
        end
    end

    // Stage 2: registered RGB outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            {red, green, blue} <= 12'h000;
        end else begin
            {red, green, blue} <= pix_s;
        end
    end

    // Single write port shared by host writes (IDLE only) and sweep steps.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {AW{1'b0}};
        ram_wdata_s = {COLOR_BITS{1'b0}};
        src_addr_s  = {AW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (wr_en && !clear_req && !collapse_req && (wr_x <= LAST_X) && (wr_y <= LAST_Y)) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = cell_addr(32'(wr_x), 32'(wr_y));
                    ram_wdata_s = wr_color;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cnt_r;
            end
            ST_SHIFT: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cell_addr(32'(x_r), 32'(y_r));
                src_addr_s  = cell_addr(32'(x_r), 32'(y_r) - 32'd1);
                ram_wdata_s = src_data_s;
            end
            ST_TOPFILL: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cell_addr(32'(x_r), 32'd0);
            end
            default: begin
                ram_we_s    = 1'b0;
            end
        endcase
    end

    // Sweep FSM with registered busy/done; reset forces a fresh clear sweep.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {AW{1'b0}};
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    x_r   <= {XW{1'b0}};
                    cnt_r <= {AW{1'b0}};
                    if (clear_req) begin
                        state_r <= ST_CLEAR;
                        busy    <= 1'b1;
                    end else if (collapse_req && (collapse_row <= LAST_Y)) begin
                        state_r <= (collapse_row == {YW{1'b0}}) ? ST_TOPFILL : ST_SHIFT;
                        y_r     <= collapse_row;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == LAST_CELL) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                ST_SHIFT: begin
                    if (x_r == LAST_X) begin
                        x_r <= {XW{1'b0}};
                        if (y_r == {{(YW-1){1'b0}}, 1'b1}) begin
                            state_r <= ST_TOPFILL;
                        end else begin
                            y_r     <= y_r - {{(YW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        x_r <= x_r + {{(XW-1){1'b0}}, 1'b1};
                    end
                end
                ST_TOPFILL: begin
                    if (x_r == LAST_X) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        x_r     <= x_r + {{(XW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= {AW{1'b0}};
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// Directed bench for vga_tile_framebuffer: default 32-px instance driven through a
// pixel scoreboard, plus a 16-px instance for the 40x30 grid corner.
module tb_vga_tile_framebuffer;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic [9:0] col = 10'd0;
    logic [8:0] row = 9'd0;
    logic       video_on = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_x = 5'd0;
    logic [3:0] wr_y = 4'd0;
    logic [2:0] wr_color = 3'd0;
    logic       clear_req = 1'b0;
    logic       collapse_req = 1'b0;
    logic [3:0] collapse_row = 4'd0;
    logic       busy, done;
    logic [3:0] red, green, blue;

    logic [9:0] col2 = 10'd0;
    logic [8:0] row2 = 9'd0;
    logic       video_on2 = 1'b0;
    logic       wr_en2 = 1'b0;
    logic [5:0] wr_x2 = 6'd0;
    logic [4:0] wr_y2 = 5'd0;
    logic [2:0] wr_color2 = 3'd0;
    logic       clear_req2 = 1'b0;
    logic       collapse_req2 = 1'b0;
    logic [4:0] collapse_row2 = 5'd0;
    logic       busy2, done2;
    logic [3:0] red2, green2, blue2;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] sb[$];
    string       tq[$];

    always #5 CLK = ~CLK;

    vga_tile_framebuffer dut (
        .CLK(CLK), .RESET_n(RESET_n), .col(col), .row(row), .video_on(video_on),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .clear_req(clear_req), .collapse_req(collapse_req), .collapse_row(collapse_row),
        .busy(busy), .done(done), .red(red), .green(green), .blue(blue)
    );

    vga_tile_framebuffer #(.BLOCK_SIZE(16)) dut16 (
        .CLK(CLK), .RESET_n(RESET_n), .col(col2), .row(row2), .video_on(video_on2),
        .wr_en(wr_en2), .wr_x(wr_x2), .wr_y(wr_y2), .wr_color(wr_color2),
        .clear_req(clear_req2), .collapse_req(collapse_req2), .collapse_row(collapse_row2),
        .busy(busy2), .done(done2), .red(red2), .green(green2), .blue(blue2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pixel applied now appears on RGB two edges later; compare the entry queued one call ago.
    task automatic scan(input logic [9:0] c, input logic [8:0] r, input logic v,
                        input logic [11:0] exp, input string tag);
        col = c; row = r; video_on = v;
        sb.push_back(exp);
        tq.push_back(tag);
        step();
        if (sb.size() == 2) chk(tq.pop_front(), {red, green, blue}, sb.pop_front());
    endtask

    task automatic flush();
        while (sb.size() > 0) begin
            col = 10'd0; row = 9'd0; video_on = 1'b0;
            step();
            chk(tq.pop_front(), {red, green, blue}, sb.pop_front());
        end
    endtask

    task automatic write_cell(input logic [4:0] x, input logic [3:0] y, input logic [2:0] c);
        wr_en = 1'b1; wr_x = x; wr_y = y; wr_color = c;
        step();
        wr_en = 1'b0;
    endtask

    // Counts edges until done, requiring busy high on every edge before it.
    task automatic run_sweep(input string tag, input int exp_cycles);
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            n++;
            if (done) break;
            if (!busy) bad++;
        end
        chk({tag, " cycles"}, n, exp_cycles);
        chk({tag, " busy gaps"}, bad, 0);
        chk({tag, " busy fall"}, busy, 1'b0);
        step();
        chk({tag, " done pulse width"}, done, 1'b0);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("reset busy", busy, 1'b1);
        chk("reset done", done, 1'b0);
        chk("reset rgb", {red, green, blue}, 12'h000);
        RESET_n = 1'b1;
        run_sweep("reset clear", 300);

        scan(10'd0,   9'd0,   1'b1, 12'h000, "blank 0,0");
        scan(10'd320, 9'd240, 1'b1, 12'h000, "blank mid");
        scan(10'd639, 9'd479, 1'b1, 12'h000, "blank corner");
        flush();

        // Basic rendering, border, and two-cycle latency via back-to-back pixels
        write_cell(5'd3, 4'd2, 3'd4);
        write_cell(5'd0, 4'd0, 3'd7);
        scan(10'd100, 9'd70, 1'b1, 12'h0F0, "green interior");
        scan(10'd96,  9'd70, 1'b1, 12'h888, "border x0");
        scan(10'd132, 9'd70, 1'b1, 12'h000, "empty neighbour");
        scan(10'd100, 9'd64, 1'b1, 12'h888, "border y0");
        scan(10'd5,   9'd5,  1'b1, 12'hF80, "orange");
        scan(10'd100, 9'd70, 1'b0, 12'h000, "video off");
        scan(10'd700, 9'd10, 1'b1, 12'h000, "off grid");
        flush();

        // Same-cycle write returns the old value, then the new one
        wr_en = 1'b1; wr_x = 5'd6; wr_y = 4'd1; wr_color = 3'd5;
        scan(10'd202, 9'd42, 1'b1, 12'h000, "same-cycle old");
        wr_en = 1'b0;
        scan(10'd202, 9'd42, 1'b1, 12'hF00, "after write red");
        flush();

        // Collapse row 9
        write_cell(5'd5, 4'd9, 3'd2);
        write_cell(5'd5, 4'd8, 3'd5);
        write_cell(5'd5, 4'd7, 3'd6);
        write_cell(5'd5, 4'd0, 3'd1);
        collapse_req = 1'b1; collapse_row = 4'd9;
        step();
        collapse_req = 1'b0;
        chk("collapse busy rise", busy, 1'b1);
        run_sweep("collapse 9", 200);
        scan(10'd170, 9'd298, 1'b1, 12'hF00, "collapse (5,9)");
        scan(10'd170, 9'd266, 1'b1, 12'h00F, "collapse (5,8)");
        scan(10'd170, 9'd234, 1'b1, 12'h000, "collapse (5,7)");
        scan(10'd170, 9'd42,  1'b1, 12'h0FF, "collapse (5,1)");
        scan(10'd170, 9'd10,  1'b1, 12'h000, "collapse (5,0)");
        scan(10'd10,  9'd10,  1'b1, 12'h000, "collapse (0,0)");
        scan(10'd106, 9'd106, 1'b1, 12'h0F0, "collapse (3,3)");
        flush();

        // Clear and collapse together select the full clear
        clear_req = 1'b1; collapse_req = 1'b1; collapse_row = 4'd3;
        step();
        clear_req = 1'b0; collapse_req = 1'b0;
        run_sweep("clear+collapse", 300);
        scan(10'd170, 9'd298, 1'b1, 12'h000, "cleared (5,9)");
        scan(10'd106, 9'd106, 1'b1, 12'h000, "cleared (3,3)");
        flush();

        // Top-fill only; write with request and write while busy both dropped
        collapse_req = 1'b1; collapse_row = 4'd0;
        wr_en = 1'b1; wr_x = 5'd2; wr_y = 4'd5; wr_color = 3'd3;
        step();
        collapse_req = 1'b0; wr_x = 5'd3; wr_color = 3'd2;
        chk("topfill busy rise", busy, 1'b1);
        step();
        wr_en = 1'b0;
        run_sweep("topfill", 19);
        scan(10'd74,  9'd170, 1'b1, 12'h000, "wr with request dropped");
        scan(10'd106, 9'd170, 1'b1, 12'h000, "wr while busy dropped");
        flush();

        // Out-of-range write and collapse row are ignored
        write_cell(5'd20, 4'd0, 3'd1);
        chk("bad wr_x busy", busy, 1'b0);
        collapse_req = 1'b1; collapse_row = 4'd15;
        step();
        collapse_req = 1'b0;
        chk("bad row busy", busy, 1'b0);
        step();
        chk("bad row still idle", busy, 1'b0);
        chk("bad row no done", done, 1'b0);
        scan(10'd10, 9'd42, 1'b1, 12'h000, "wr_x=20 no alias");
        write_cell(5'd4, 4'd4, 3'd3);
        scan(10'd138, 9'd138, 1'b0, 12'h000, "purple video off");
        scan(10'd138, 9'd138, 1'b1, 12'h80F, "purple");
        flush();

        // 16-pixel cells: 40x30 grid, far corner cell
        for (int i = 0; i < 3000 && busy2; i++) step();
        chk("bs16 clear finished", busy2, 1'b0);
        wr_en2 = 1'b1; wr_x2 = 6'd39; wr_y2 = 5'd29; wr_color2 = 3'd1;
        step();
        wr_en2 = 1'b0;
        col2 = 10'd632; row2 = 9'd472; video_on2 = 1'b1;
        step(); step();
        chk("bs16 corner cyan", {red2, green2, blue2}, 12'h0FF);
        col2 = 10'd624;
        step(); step();
        chk("bs16 corner border", {red2, green2, blue2}, 12'h888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
